// File: rtl/ysyx_22050019_lsu.sv
// Load/store unit: takes one memory request from execute, issues a single aligned
// 64-bit bus access, steers byte lanes/strobes, extends load data and pulses a response.
module ysyx_22050019_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        ram_re,
  input  logic        ram_we,
  input  logic [63:0] addr,
  input  logic [63:0] ram_wdata,
  input  logic [5:0]  mem_r_wdth,
  input  logic [3:0]  mem_w_wdth,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [63:0] mem_req_addr,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [63:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic        sext_q, we_q, err_q;
  logic [31:0] cnt_q;

  logic [1:0]  size_d;
  logic        sext_d, multi_hot, misalign, access, acc_err, timeout_hit;
  logic [63:0] lane, load_ext;

  // Width decode: size is log2 of the access in bytes; an all-zero width vector means 64-bit.
  always_comb begin
    size_d    = 2'd3;
    sext_d    = 1'b0;
    multi_hot = 1'b0;
    if (ram_we) begin
      multi_hot = (mem_w_wdth & (mem_w_wdth - 4'd1)) != 4'd0;
      if (mem_w_wdth[2])      size_d = 2'd0;
      else if (mem_w_wdth[1]) size_d = 2'd1;
      else if (mem_w_wdth[0]) size_d = 2'd2;
    end else begin
      multi_hot = (mem_r_wdth & (mem_r_wdth - 6'd1)) != 6'd0;
      if (mem_r_wdth[3] || mem_r_wdth[0])      size_d = 2'd0;
      else if (mem_r_wdth[4] || mem_r_wdth[1]) size_d = 2'd1;
      else if (mem_r_wdth[5] || mem_r_wdth[2]) size_d = 2'd2;
      sext_d = mem_r_wdth[5] | mem_r_wdth[4] | mem_r_wdth[3];
    end
    case (size_d)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = addr[0];
      2'd2:    misalign = |addr[1:0];
      default: misalign = |addr[2:0];
    endcase
    access  = ram_re ^ ram_we;
    acc_err = (ram_re & ram_we) | (access & (multi_hot | misalign));
  end

  always_comb begin
    lane = mem_rsp_rdata >> {addr_q[2:0], 3'b000};
    case (size_q)
      2'd0:    load_ext = sext_q ? {{56{lane[7]}}, lane[7:0]}   : {56'd0, lane[7:0]};
      2'd1:    load_ext = sext_q ? {{48{lane[15]}}, lane[15:0]} : {48'd0, lane[15:0]};
      2'd2:    load_ext = sext_q ? {{32{lane[31]}}, lane[31:0]} : {32'd0, lane[31:0]};
      default: load_ext = lane;
    endcase
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Errors and non-memory instructions skip the bus and respond on the next cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = (acc_err || !access) ? RESP : REQ;
      REQ:  if (mem_req_ready) state_nxt = WAIT;
      WAIT: if (mem_rsp_valid || timeout_hit) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      size_q  <= 2'd0;
      sext_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q  <= addr;
          wdata_q <= ram_wdata;
          size_q  <= size_d;
          sext_q  <= sext_d;
          we_q    <= ram_we & ~ram_re;
          rdata_q <= 64'd0;
          err_q   <= acc_err;
        end
        REQ: if (mem_req_ready) cnt_q <= 32'd0;
        WAIT: begin
          // A response arriving in the timeout cycle still completes cleanly.
          if (mem_rsp_valid) begin
            rdata_q <= we_q ? 64'd0 : load_ext;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= 64'd0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready     = (state == IDLE);
    mem_req_valid = (state == REQ);
    rsp_valid     = (state == RESP);
    rsp_rdata     = (state == RESP) ? rdata_q : 64'd0;
    rsp_err       = (state == RESP) ? err_q : 1'b0;
    mem_req_we    = we_q;
    mem_req_addr  = {addr_q[63:3], 3'b000};
    mem_req_wdata = we_q ? (wdata_q << {addr_q[2:0], 3'b000}) : 64'd0;
    mem_req_wstrb = 8'h00;
    if (we_q) begin
      case (size_q)
        2'd0:    mem_req_wstrb = 8'h01 << addr_q[2:0];
        2'd1:    mem_req_wstrb = 8'h03 << addr_q[2:0];
        2'd2:    mem_req_wstrb = 8'h0F << addr_q[2:0];
        default: mem_req_wstrb = 8'hFF;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_lsu.sv
// Directed bench for the LSU: loads, stores, early errors, bus stalls, timeout and
// asynchronous reset mid-transaction, each with hand-computed expectations.
module tb_ysyx_22050019_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, ram_re, ram_we;
  logic [63:0] addr, ram_wdata;
  logic [5:0]  mem_r_wdth;
  logic [3:0]  mem_w_wdth;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;

  int errors = 0;
  int checks = 0;

  ysyx_22050019_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .ram_re(ram_re), .ram_we(ram_we), .addr(addr), .ram_wdata(ram_wdata),
    .mem_r_wdth(mem_r_wdth), .mem_w_wdth(mem_w_wdth),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req_valid  = 1'b0;
    ram_re     = 1'b0;
    ram_we     = 1'b0;
    addr       = 64'd0;
    ram_wdata  = 64'd0;
    mem_r_wdth = 6'd0;
    mem_w_wdth = 4'd0;
  endtask

  task automatic drive_req(input logic re, input logic we, input logic [63:0] a,
                           input logic [63:0] wd, input logic [5:0] rw, input logic [3:0] ww);
    req_valid  = 1'b1;
    ram_re     = re;
    ram_we     = we;
    addr       = a;
    ram_wdata  = wd;
    mem_r_wdth = rw;
    mem_w_wdth = ww;
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 64'd0;
    clear_inputs();
    repeat (2) tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %0b expected 1", req_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req_valid: got %0b expected 0", mem_req_valid); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_err: got %0b expected 0", rsp_err); end
    checks++; if (rsp_rdata !== 64'd0) begin errors++; $display("[TB] FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
    checks++; if (mem_req_wstrb !== 8'd0) begin errors++; $display("[TB] FAIL reset_wstrb: got %h expected 0", mem_req_wstrb); end
    checks++; if (mem_req_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %0b expected 0", mem_req_we); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_loads;
    logic [63:0] a_tab [7];
    logic [5:0]  w_tab [7];
    logic [63:0] d_tab [7];
    logic [63:0] e_tab [7];
    a_tab = '{64'h8000_0003, 64'h8000_0006, 64'h8000_0004, 64'h8000_0004,
              64'h8000_0008, 64'h8000_0002, 64'h8000_0007};
    w_tab = '{6'b001000, 6'b000010, 6'b100000, 6'b000100, 6'b000000, 6'b010000, 6'b000001};
    d_tab = '{64'h1122_3344_8566_7788, 64'hABCD_0000_0000_0000, 64'h8000_0000_1234_5678,
              64'h8000_0000_1234_5678, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_F00D_0000,
              64'h9A00_0000_0000_0000};
    e_tab = '{64'hFFFF_FFFF_FFFF_FF85, 64'h0000_0000_0000_ABCD, 64'hFFFF_FFFF_8000_0000,
              64'h0000_0000_8000_0000, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_F00D,
              64'h0000_0000_0000_009A};
    mem_req_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive_req(1'b1, 1'b0, a_tab[i], 64'd0, w_tab[i], 4'd0);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL load%0d_req_ready: got %0b expected 1", i, req_ready); end
      tick();
      clear_inputs();
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL load%0d_mem_req_valid: got %0b expected 1", i, mem_req_valid); end
      checks++; if (mem_req_addr !== (a_tab[i] & ~64'h7)) begin errors++; $display("[TB] FAIL load%0d_addr: got %h expected %h", i, mem_req_addr, a_tab[i] & ~64'h7); end
      checks++; if (mem_req_wstrb !== 8'h00 || mem_req_we !== 1'b0) begin errors++; $display("[TB] FAIL load%0d_wstrb_we: got %h/%0b expected 00/0", i, mem_req_wstrb, mem_req_we); end
      tick();
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = d_tab[i];
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL load%0d_early_rsp: got %0b expected 0", i, rsp_valid); end
      tick();
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = 64'd0;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL load%0d_rsp_valid: got %0b expected 1", i, rsp_valid); end
      checks++; if (rsp_rdata !== e_tab[i]) begin errors++; $display("[TB] FAIL load%0d_rdata: got %h expected %h", i, rsp_rdata, e_tab[i]); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL load%0d_err: got %0b expected 0", i, rsp_err); end
      tick();
      checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 64'd0) begin errors++; $display("[TB] FAIL load%0d_rsp_drop: got %0b/%h expected 0/0", i, rsp_valid, rsp_rdata); end
    end
  endtask

  task automatic test_stores;
    logic [63:0] a_tab [5];
    logic [3:0]  w_tab [5];
    logic [63:0] d_tab [5];
    logic [63:0] e_tab [5];
    logic [7:0]  s_tab [5];
    a_tab = '{64'h8000_0002, 64'h8000_0007, 64'h8000_0004, 64'h8000_0010, 64'h8000_0018};
    w_tab = '{4'b0010, 4'b0100, 4'b0001, 4'b0000, 4'b1000};
    d_tab = '{64'h0000_0000_1234_BEEF, 64'h0000_0000_0000_00AB, 64'h0000_0000_CAFE_F00D,
              64'h0102_0304_0506_0708, 64'hFFEE_DDCC_BBAA_9988};
    e_tab = '{64'h0000_1234_BEEF_0000, 64'hAB00_0000_0000_0000, 64'hCAFE_F00D_0000_0000,
              64'h0102_0304_0506_0708, 64'hFFEE_DDCC_BBAA_9988};
    s_tab = '{8'h0C, 8'h80, 8'hF0, 8'hFF, 8'hFF};
    mem_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_req(1'b0, 1'b1, a_tab[i], d_tab[i], 6'd0, w_tab[i]);
      tick();
      clear_inputs();
      checks++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b1) begin errors++; $display("[TB] FAIL store%0d_valid_we: got %0b/%0b expected 1/1", i, mem_req_valid, mem_req_we); end
      checks++; if (mem_req_wstrb !== s_tab[i]) begin errors++; $display("[TB] FAIL store%0d_wstrb: got %h expected %h", i, mem_req_wstrb, s_tab[i]); end
      checks++; if (mem_req_wdata !== e_tab[i]) begin errors++; $display("[TB] FAIL store%0d_wdata: got %h expected %h", i, mem_req_wdata, e_tab[i]); end
      checks++; if (mem_req_addr !== (a_tab[i] & ~64'h7)) begin errors++; $display("[TB] FAIL store%0d_addr: got %h expected %h", i, mem_req_addr, a_tab[i] & ~64'h7); end
      tick();
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      tick();
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = 64'd0;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'd0 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL store%0d_rsp: got %0b/%h/%0b expected 1/0/0", i, rsp_valid, rsp_rdata, rsp_err); end
      tick();
    end
  endtask

  task automatic test_errors;
    logic        re_tab [7];
    logic        we_tab [7];
    logic [63:0] a_tab  [7];
    logic [5:0]  rw_tab [7];
    logic [3:0]  ww_tab [7];
    logic        e_tab  [7];
    re_tab = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    we_tab = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    a_tab  = '{64'h8000_0002, 64'h8000_0000, 64'h8000_0002, 64'h8000_0000,
               64'h8000_0001, 64'h8000_0004, 64'h8000_0000};
    rw_tab = '{6'b100000, 6'b000000, 6'b000000, 6'b001001, 6'b000000, 6'b000000, 6'b000000};
    ww_tab = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b1100};
    e_tab  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    mem_req_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive_req(re_tab[i], we_tab[i], a_tab[i], 64'h5A5A_5A5A_5A5A_5A5A, rw_tab[i], ww_tab[i]);
      tick();
      clear_inputs();
      checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL err%0d_no_bus: got %0b expected 0", i, mem_req_valid); end
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL err%0d_rsp_valid: got %0b expected 1", i, rsp_valid); end
      checks++; if (rsp_err !== e_tab[i]) begin errors++; $display("[TB] FAIL err%0d_rsp_err: got %0b expected %0b", i, rsp_err, e_tab[i]); end
      checks++; if (rsp_rdata !== 64'd0) begin errors++; $display("[TB] FAIL err%0d_rdata: got %h expected 0", i, rsp_rdata); end
      tick();
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL err%0d_back_idle: got %0b/%0b expected 0/1", i, rsp_valid, req_ready); end
    end
  endtask

  task automatic test_stall;
    mem_req_ready = 1'b0;
    drive_req(1'b1, 1'b0, 64'h8000_0020, 64'd0, 6'd0, 4'd0);
    tick();
    clear_inputs();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) mem_req_ready = 1'b1;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0020) begin errors++; $display("[TB] FAIL stall%0d_req: got %0b/%h expected 1/0000000080000020", i, mem_req_valid, mem_req_addr); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall%0d_req_ready: got %0b expected 0", i, req_ready); end
      tick();
    end
    mem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (mem_req_valid !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_wait%0d: got %0b/%0b/%0b expected 0/0/0", i, mem_req_valid, rsp_valid, req_ready); end
      tick();
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 64'h5555_AAAA_0F0F_F0F0;
    tick();
    mem_rsp_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h5555_AAAA_0F0F_F0F0) begin errors++; $display("[TB] FAIL stall_rsp: got %0b/%h expected 1/5555aaaa0f0ff0f0", rsp_valid, rsp_rdata); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_single_pulse: got %0b/%0b expected 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_timeout;
    mem_req_ready = 1'b1;
    drive_req(1'b1, 1'b0, 64'h8000_0000, 64'd0, 6'd0, 4'd0);
    tick();
    clear_inputs();
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL timeout_wait%0d: got %0b expected 0", i, rsp_valid); end
      tick();
    end
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 64'd0) begin errors++; $display("[TB] FAIL timeout_rsp: got %0b/%0b/%h expected 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 64'h1111_2222_3333_4444;
    tick();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL timeout_late_rsp1: got %0b/%0b/%0b expected 0/1/0", rsp_valid, req_ready, mem_req_valid); end
    tick();
    mem_rsp_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL timeout_late_rsp2: got %0b/%0b expected 0/1", rsp_valid, req_ready); end
    // Response in the very cycle the timeout would fire.
    drive_req(1'b1, 1'b0, 64'h8000_0000, 64'd0, 6'd0, 4'd0);
    tick();
    clear_inputs();
    tick();
    repeat (3) tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 64'h7777_6666_5555_4444;
    tick();
    mem_rsp_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 64'h7777_6666_5555_4444) begin errors++; $display("[TB] FAIL timeout_race: got %0b/%0b/%h expected 1/0/7777666655554444", rsp_valid, rsp_err, rsp_rdata); end
    tick();
  endtask

  task automatic test_reset_mid;
    mem_req_ready = 1'b0;
    drive_req(1'b1, 1'b0, 64'h8000_0040, 64'd0, 6'd0, 4'd0);
    tick();
    clear_inputs();
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_req_before: got %0b expected 1", mem_req_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_req_async: got %0b/%0b expected 0/1", mem_req_valid, req_ready); end
    tick();
    rst_n = 1'b1;
    mem_req_ready = 1'b1;
    tick();
    drive_req(1'b1, 1'b0, 64'h8000_0040, 64'd0, 6'd0, 4'd0);
    tick();
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_wait_async: got %0b/%0b/%0b expected 1/0/0", req_ready, rsp_valid, mem_req_valid); end
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_in_reset_rsp: got %0b expected 0", rsp_valid); end
    tick();
    mem_rsp_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_stray_rsp: got %0b/%0b expected 0/1", rsp_valid, req_ready); end
    drive_req(1'b1, 1'b0, 64'h8000_0001, 64'd0, 6'b001000, 4'd0);
    tick();
    clear_inputs();
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 64'h0000_0000_0000_7F00;
    tick();
    mem_rsp_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h0000_0000_0000_007F || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_recover: got %0b/%h/%0b expected 1/000000000000007f/0", rsp_valid, rsp_rdata, rsp_err); end
    tick();
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_stall();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
